// File: rtl/spram_arbiter_pkg.sv
// Shared types for the single-port SRAM arbiter: port identifiers and port count.
package spram_arbiter_pkg;

  typedef enum logic {PORT_INSTR = 1'b0, PORT_DATA = 1'b1} port_e;

  localparam int NPORTS = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: one-hot grant in the same cycle, tie goes to
// the port that was not granted most recently.
module rr_arbiter2
  import spram_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] gnt
);

  port_e last_grant;

  always_comb begin
    gnt = '0;
    if (req[PORT_INSTR] && req[PORT_DATA]) begin
      if (last_grant == PORT_INSTR) gnt[PORT_DATA]  = 1'b1;
      else                          gnt[PORT_INSTR] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  last_grant <= PORT_INSTR;
    else if (gnt[PORT_DATA])  last_grant <= PORT_DATA;
    else if (gnt[PORT_INSTR]) last_grant <= PORT_INSTR;
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port byte-masked SRAM between the fetch port and the data port,
// one access per cycle, ack one cycle after grant aligned with the SRAM read latency.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int KB     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] instr_addr,
  input  logic              instr_req,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic [AWIDTH-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  input  logic [3:0]        data_mask,
  input  logic              data_we,
  input  logic              data_req,
  output logic              data_ack,
  output logic [31:0]       data_rdata,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_mask,
  output logic              mem_en,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rdata
);

  localparam logic [AWIDTH-1:0] MEM_BYTES = AWIDTH'(KB * 1024);

  logic [NPORTS-1:0] req, eligible, gnt, ack_q, oor_q;
  logic              instr_oor, data_oor;

  assign instr_oor = (instr_addr >= MEM_BYTES);
  assign data_oor  = (data_addr  >= MEM_BYTES);

  assign req[PORT_INSTR] = instr_req;
  assign req[PORT_DATA]  = data_req;

  // A port in its ack cycle is masked so a held request is not issued twice;
  // masking on rst keeps the SRAM idle throughout reset.
  assign eligible = req & ~ack_q & {NPORTS{~rst}};

  rr_arbiter2 u_rr (
    .clk (clk),
    .rst (rst),
    .req (eligible),
    .gnt (gnt)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_en    = 1'b0;
    mem_wr_en = 1'b0;
    if (gnt[PORT_DATA]) begin
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_mask  = data_mask;
      mem_en    = ~data_oor;
      mem_wr_en = data_we & ~data_oor;
    end else if (gnt[PORT_INSTR]) begin
      mem_addr  = instr_addr;
      mem_en    = ~instr_oor;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= '0;
      oor_q <= '0;
    end else begin
      ack_q            <= gnt;
      oor_q[PORT_INSTR] <= gnt[PORT_INSTR] & instr_oor;
      oor_q[PORT_DATA]  <= gnt[PORT_DATA]  & data_oor;
    end
  end

  assign instr_ack  = ack_q[PORT_INSTR];
  assign data_ack   = ack_q[PORT_DATA];
  assign instr_data = (ack_q[PORT_INSTR] && !oor_q[PORT_INSTR]) ? mem_rdata : '0;
  assign data_rdata = (ack_q[PORT_DATA]  && !oor_q[PORT_DATA])  ? mem_rdata : '0;

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one single-port 32-bit byte-masked SRAM between the core's instruction-fetch port (read-only) and data port (read/write).
- Each requester uses a Wishbone-classic style request/ack handshake.
- Grants one memory access per cycle with round-robin fairness and returns the ack one cycle after the grant, aligned with the SRAM's 1-cycle read latency.
- Sits between the core's bus ports and the generic single-port SRAM in the system top.

Parameters:
- AWIDTH, 32, address width of requester and memory address buses.
- KB, 4, memory size in KB; accesses with address at or above KB*1024 are out of range.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- instr_addr  in  AWIDTH  fetch byte address; bits [1:0] ignored
- instr_req  in  1  fetch request; held until instr_ack
- instr_ack  out  1  fetch complete; one-cycle pulse
- instr_data  out  32  fetch read data; valid only while instr_ack=1
- data_addr  in  AWIDTH  data byte address; bits [1:0] ignored
- data_wdata  in  32  write data
- data_mask  in  4  byte enables, applied to writes only
- data_we  in  1  1=write, 0=read
- data_req  in  1  data request; held with stable fields until data_ack
- data_ack  out  1  data complete; one-cycle pulse
- data_rdata  out  32  read data; valid only while data_ack=1
- mem_addr  out  AWIDTH  to SRAM addr
- mem_wdata  out  32  to SRAM wdata
- mem_mask  out  4  to SRAM mask
- mem_en  out  1  to SRAM en
- mem_wr_en  out  1  to SRAM wr_en
- mem_rdata  in  32  from SRAM rdata; valid the cycle after a read grant

Behaviour:
- Eligibility: a port is eligible in cycle N when req=1 and it was not granted in cycle N-1 (its ack cycle). This prevents a held req from being re-issued.
- Grant (combinational, same cycle):
  - One eligible port: that port is granted.
  - Both eligible: the port not granted most recently wins.
  - last_grant register resets to INSTR, so data wins the first tie.
- mem_* outputs (combinational) for the granted port:
  - mem_en=1.
  - mem_addr = the granted port's address.
  - Instruction grant: mem_wr_en=0, mem_mask=4'h0, mem_wdata=0.
  - Data grant: mem_wr_en=data_we, mem_mask=data_mask, mem_wdata=data_wdata.
- No grant: mem_en=0, mem_wr_en=0, mem_mask=0; mem_addr and mem_wdata=0.
- Out-of-range request (addr >= KB*1024):
  - Still granted and acked with normal timing, but mem_en=0 (no SRAM access).
  - The corresponding rdata reads 32'h0 in the ack cycle.
  - Out-of-range writes are dropped.
- Ack: registered. *_ack=1 exactly in cycle N+1 for a grant in cycle N, for both reads and writes.
- Read data: instr_data and data_rdata are driven from mem_rdata in the ack cycle; forced to 0 when not acking or when the access was out of range.
- Latency: req asserted in an idle cycle with no contention gives ack on the next cycle (1 cycle). Under contention the loser is granted the next cycle and acked 2 cycles after its req.
- Throughput: with both ports continuously requesting, grants alternate I,D,I,D…, giving 100% SRAM utilization and 1 access per 2 cycles per port.
- A port deasserting req without an ack is illegal; no recovery is specified.
- Reset (asynchronous, any time, including mid-access):
  - Both acks clear to 0, pending/out-of-range flags clear, last_grant=INSTR.
  - An in-flight access is abandoned without an ack.
  - mem_en is 0 while rst=1.
- Reset values of all registered outputs: 0.

Decomposition:
- Package spram_arbiter_pkg holds:
  - typedef enum logic {PORT_INSTR, PORT_DATA} port_e;
  - localparam NPORTS = 2.
- Sub-module rr_arbiter2 holds the two-request round-robin pick and the last_grant register (inputs: clk, rst, req[1:0]; output: one-hot gnt[1:0]).
- Top level holds eligibility masking, mem mux, range check and ack/response registers.

Test Plan:
- Single fetch: instr_req=1, addr=0x10, MEM word 4 = 0xDEADBEEF -> mem_en=1 same cycle; instr_ack=1 and instr_data=0xDEADBEEF next cycle; no second grant while req is held.
- Masked write then read:
  - Stimulus: data write to 0x20 with wdata=0x11223344 and mask=4'b0101 over old value 0xAABBCCDD, then a read of 0x20.
  - Response: write acked in 1 cycle; read returns 0xAA22CC44.
- Simultaneous requests from reset: both req=1 in the same cycle -> data granted first, instr the next cycle; acks are data at N+1 and instr at N+2; mem_en stays high for 2 consecutive cycles.
- Sustained contention: both ports re-request immediately after each ack for 20 cycles -> strict I/D alternation; each port receives 10 acks; mem_en=1 every cycle.
- Out of range (KB=4): data read of 0x1000 -> mem_en=0, data_ack=1 next cycle, data_rdata=0. Data write of 0x1004 -> acked, memory unchanged.
- Reset mid-access: assert rst in the cycle after a data grant -> data_ack=0 immediately (asynchronous); after release, the held data_req is re-granted and acked normally.
